fnd_scan_driver: RTL and testbench



---
 rtl/fnd_pkg.sv | 39 +++
 rtl/fnd_bin2bcd.sv | 50 +++++
 rtl/fnd_scan_driver.sv | 87 ++++++++
 tb/tb_fnd_scan_driver.sv | 123 ++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: segment codes, converter states and BCD helpers shared by the FND scan driver.
package fnd_pkg;
  localparam int DIGIT_COUNT = 4;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_t;
  typedef logic [15:0] bcd_t;
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0: seg_code = SEG_0;
      4'd1: seg_code = SEG_1;
      4'd2: seg_code = SEG_2;
      4'd3: seg_code = SEG_3;
      4'd4: seg_code = SEG_4;
      4'd5: seg_code = SEG_5;
      4'd6: seg_code = SEG_6;
      4'd7: seg_code = SEG_7;
      4'd8: seg_code = SEG_8;
      4'd9: seg_code = SEG_9;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction
  function automatic bcd_t bcd_adjust(input bcd_t b);
    bcd_t r;
    r = b;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    return r;
  endfunction
endpackage

// File: rtl/fnd_bin2bcd.sv
// fnd_bin2bcd: iterative double-dabble converter, 14-bit binary to saturated 4-digit BCD.
module fnd_bin2bcd import fnd_pkg::*; #(
  parameter int SAT_VALUE = 9999
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        start,
  input  logic [13:0] value,
  output logic        busy,
  output logic        done,
  output bcd_t        bcd,
  output logic        ovf
);
  conv_state_t state;
  logic [29:0] sr;
  logic [3:0] cnt;
  logic [13:0] sat_v;
  assign sat_v = (value > 14'(SAT_VALUE)) ? 14'(SAT_VALUE) : value;
  assign busy = state != IDLE;
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      bcd <= '0;
      ovf <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: state <= start ? LOAD : IDLE;
        LOAD: begin
          sr <= {16'd0, sat_v};
          ovf <= value > 14'(SAT_VALUE);
          cnt <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          sr <= {bcd_adjust(sr[29:14]), sr[13:0]} << 1;
          cnt <= cnt + 4'd1;
          state <= (cnt == 4'd13) ? DONE : SHIFT;
        end
        DONE: begin
          bcd <= sr[29:14];
          done <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: 4-digit common-anode FND scanner with frame-aligned commit and ghost blanking.
// Optional FND_LEADING_ZERO_BLANK_EN suppresses leading zeros on digits 3..1.
module fnd_scan_driver import fnd_pkg::*; #(
  parameter int BLANK_CYCLES = 2,
  parameter int SAT_VALUE = 9999
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_scan_clk,
  input  logic [13:0] i_value,
  output logic [3:0]  o_digit,
  output logic [7:0]  o_seg,
  output logic        o_ovf,
  output logic        o_frame
);
  logic sync1, sync2, prev, tick, wrap, start, commit, lz;
  logic pend_v, pend_ovf, busy, done, conv_ovf;
  logic [1:0] idx, idx_n;
  logic [3:0] dig_n;
  logic [7:0] bcnt, seg_n;
  bcd_t cur, pend, view, conv_bcd;
  assign tick = sync2 & ~prev;
  assign idx_n = idx + 2'd1;
  assign wrap = tick && idx == 2'(DIGIT_COUNT - 1);
  assign start = tick && idx == 2'(DIGIT_COUNT - 2);
  assign commit = wrap && pend_v && !busy;
  // Digit 0 of a new frame must already come from the value being committed
  assign view = commit ? pend : cur;
  assign dig_n = ~(4'b0001 << idx_n);
`ifdef FND_LEADING_ZERO_BLANK_EN
  assign lz = (idx_n == 2'd3) ? view[15:12] == 4'd0 :
              (idx_n == 2'd2) ? view[15:8] == 8'd0 :
              (idx_n == 2'd1) ? view[15:4] == 12'd0 : 1'b0;
`else
  assign lz = 1'b0;
`endif
  assign seg_n = lz ? SEG_BLANK : seg_code(view[{idx_n, 2'b00} +: 4]);
  fnd_bin2bcd #(.SAT_VALUE(SAT_VALUE)) u_conv (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .start(start),
    .value(i_value),
    .busy(busy),
    .done(done),
    .bcd(conv_bcd),
    .ovf(conv_ovf)
  );
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      {sync1, sync2, prev} <= 3'b000;
      idx <= '0;
      bcnt <= '0;
      o_digit <= 4'hF;
      o_seg <= SEG_BLANK;
      o_ovf <= 1'b0;
      o_frame <= 1'b0;
      cur <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      pend_ovf <= 1'b0;
    end else begin
      {sync1, sync2, prev} <= {i_scan_clk, sync1, sync2};
      o_frame <= wrap;
      if (tick) begin
        idx <= idx_n;
        o_seg <= seg_n;
        if (BLANK_CYCLES == 0) o_digit <= dig_n;
        else begin
          o_digit <= 4'hF;
          bcnt <= 8'(BLANK_CYCLES);
        end
      end else if (bcnt != 8'd0) begin
        bcnt <= bcnt - 8'd1;
        if (bcnt == 8'd1) o_digit <= ~(4'b0001 << idx);
      end
      if (commit) begin
        cur <= pend;
        o_ovf <= pend_ovf;
        pend_v <= 1'b0;
      end
      if (done) begin
        pend <= conv_bcd;
        pend_ovf <= conv_ovf;
        pend_v <= 1'b1;
      end
    end
endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver: directed checks of scan order, commit timing, saturation and blanking.
module tb_fnd_scan_driver;
  logic i_clk = 1'b0, i_reset = 1'b1, i_scan_clk = 1'b0;
  logic [13:0] i_value = 14'd1234;
  logic [3:0] o_digit, nb_digit;
  logic [7:0] o_seg, nb_seg;
  logic o_ovf, nb_ovf, o_frame, nb_frame;
  int errors = 0, checks = 0, frames = 0;
`ifdef FND_LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;
`else
  localparam logic [7:0] LZ = 8'hC0;
`endif
  fnd_scan_driver dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_scan_clk(i_scan_clk), .i_value(i_value),
    .o_digit(o_digit), .o_seg(o_seg), .o_ovf(o_ovf), .o_frame(o_frame)
  );
  fnd_scan_driver #(.BLANK_CYCLES(0)) u_nb (
    .i_clk(i_clk), .i_reset(i_reset), .i_scan_clk(i_scan_clk), .i_value(i_value),
    .o_digit(nb_digit), .o_seg(nb_seg), .o_ovf(nb_ovf), .o_frame(nb_frame)
  );
  always #5 i_clk = ~i_clk;
  always @(negedge i_clk) if (o_frame) frames <= frames + 1;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input string tag, input logic [3:0] dig, input logic [7:0] seg);
    @(negedge i_clk) i_scan_clk = 1'b1;
    repeat (8) @(negedge i_clk);
    check({tag, " digit"}, 16'(o_digit), 16'(dig));
    check({tag, " seg"}, 16'(o_seg), 16'(seg));
    check({tag, " nb seg"}, 16'(nb_seg), 16'(seg));
    i_scan_clk = 1'b0;
    repeat (22) @(negedge i_clk);
  endtask
  initial begin
    repeat (5) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (5) @(negedge i_clk);
    tick("pre1", 4'hD, LZ);
    tick("pre2", 4'hB, LZ);
    @(negedge i_clk) i_scan_clk = 1'b1;
    repeat (8) @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check("rst digit", 16'(o_digit), 16'hF);
    check("rst seg", 16'(o_seg), 16'hFF);
    check("rst ovf", 16'(o_ovf), 16'h0);
    check("rst frame", 16'(o_frame), 16'h0);
    i_scan_clk = 1'b0;
    repeat (5) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (20) @(negedge i_clk);
    tick("t1", 4'hD, LZ);
    tick("t2", 4'hB, LZ);
    tick("t3", 4'h7, LZ);
    check("frames t3", 16'(frames), 16'd0);
    tick("t4", 4'hE, 8'h99);
    check("frames t4", 16'(frames), 16'd1);
    check("ovf 1234", 16'(o_ovf), 16'h0);
    tick("t5", 4'hD, 8'hB0);
    tick("t6", 4'hB, 8'hA4);
    tick("t7", 4'h7, 8'hF9);
    tick("t8", 4'hE, 8'h99);
    check("frames t8", 16'(frames), 16'd2);
    i_value = 14'd12000;
    tick("t9", 4'hD, 8'hB0);
    tick("t10", 4'hB, 8'hA4);
    tick("t11", 4'h7, 8'hF9);
    check("ovf pre", 16'(o_ovf), 16'h0);
    tick("t12", 4'hE, 8'h90);
    check("ovf sat", 16'(o_ovf), 16'h1);
    i_value = 14'd5;
    tick("t13", 4'hD, 8'h90);
    tick("t14", 4'hB, 8'h90);
    tick("t15", 4'h7, 8'h90);
    check("ovf held", 16'(o_ovf), 16'h1);
    tick("t16", 4'hE, 8'h92);
    check("ovf clr", 16'(o_ovf), 16'h0);
    i_value = 14'd1111;
    tick("t17", 4'hD, LZ);
    tick("t18", 4'hB, LZ);
    tick("t19", 4'h7, LZ);
    tick("t20", 4'hE, 8'hF9);
    i_value = 14'd2222;
    tick("t21", 4'hD, 8'hF9);
    tick("t22", 4'hB, 8'hF9);
    tick("t23", 4'h7, 8'hF9);
    tick("t24", 4'hE, 8'hA4);
    tick("t25", 4'hD, 8'hA4);
    i_value = 14'd7;
    tick("t26", 4'hB, 8'hA4);
    tick("t27", 4'h7, 8'hA4);
    tick("t28", 4'hE, 8'hF8);
    tick("t29", 4'hD, LZ);
    tick("t30", 4'hB, LZ);
    i_value = 14'd0;
    tick("t31", 4'h7, LZ);
    tick("t32", 4'hE, 8'hC0);
    check("frames t32", 16'(frames), 16'd8);
    @(negedge i_clk) i_scan_clk = 1'b1;
    repeat (2) @(negedge i_clk);
    check("blk pre", 16'(o_digit), 16'hE);
    check("nb pre", 16'(nb_digit), 16'hE);
    @(negedge i_clk);
    check("blk c1", 16'(o_digit), 16'hF);
    check("nb tick", 16'(nb_digit), 16'hD);
    check("blk seg", 16'(o_seg), 16'(LZ));
    @(negedge i_clk);
    check("blk c2", 16'(o_digit), 16'hF);
    @(negedge i_clk);
    check("blk on", 16'(o_digit), 16'hD);
    i_scan_clk = 1'b0;
    repeat (10) @(negedge i_clk);
    check("fall no-op", 16'(o_digit), 16'hD);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
